// File: rtl/multi_digit_display.sv
// Time-multiplexed N-digit seven-segment driver with sequential binary-to-BCD
// conversion (double-dabble), leading-zero blanking, DP, overflow and blinking error.
// Ports: clock/resetN (async, active-low); value+load start a conversion and
// busy flags it; isError/blankZeros/dpEnable/dpPosition are level controls;
// digitEnable is a one-hot digit select; A..G and DP are the segment drives.
module multi_digit_display #(
    parameter int DIGITS         = 4,
    parameter int VALUE_WIDTH    = 14,
    parameter int SCAN_DIV       = 1000,
    parameter int BLINK_DIV      = 50,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic                   clock,
    input  logic                   resetN,
    input  logic [VALUE_WIDTH-1:0] value,
    input  logic                   load,
    input  logic                   isError,
    input  logic                   blankZeros,
    input  logic                   dpEnable,
    input  logic [2:0]             dpPosition,
    output logic                   busy,
    output logic [DIGITS-1:0]      digitEnable,
    output logic                   A,
    output logic                   B,
    output logic                   C,
    output logic                   D,
    output logic                   E,
    output logic                   F,
    output logic                   G,
    output logic                   DP
);

    // Every 3 binary bits need at most one decimal digit.
    localparam int NB0 = (VALUE_WIDTH + 2) / 3;
    localparam int NB  = (NB0 > DIGITS) ? NB0 : DIGITS;
    localparam int CW  = $clog2(VALUE_WIDTH + 1);
    localparam int PW  = $clog2(SCAN_DIV);
    localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BW  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int SW  = NB * 4 + VALUE_WIDTH;
    localparam logic [7:0] SEG_OFF = {8{SEG_ACTIVE_LOW}};

    logic                   r_busy;
    logic [CW-1:0]          r_cnt;
    logic [VALUE_WIDTH-1:0] r_bin;
    logic [NB*4-1:0]        r_bcd;
    logic [DIGITS*4-1:0]    r_disp;
    logic                   r_ovf;

    logic [PW-1:0]          r_pre;
    logic [IW-1:0]          r_idx;
    logic                   r_run;
    logic [BW-1:0]          r_bcnt;
    logic                   r_phase;
    logic [DIGITS-1:0]      r_en;
    logic [7:0]             r_seg;

    logic [NB*4-1:0]        w_adj;
    logic [SW-1:0]          w_sh;
    logic                   w_ovf;
    logic                   w_done;
    logic                   w_accept;
    logic                   w_term;
    logic                   w_wrap;
    logic [3:0]             w_bcd;
    logic [6:0]             w_code;
    logic [DIGITS-1:0]      w_lead;
    logic                   w_z;
    logic [3:0]             w_idx4;
    logic [3:0]             w_dp4;
    logic                   w_blank;
    logic                   w_dp;
    logic [7:0]             w_seg;
    logic [DIGITS-1:0]      w_onehot;

    // Double-dabble step: add 3 to every digit >= 5, then shift in one bit.
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < NB; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
        w_sh = {w_adj, r_bin} << 1;
        w_ovf = 1'b0;
        for (int i = DIGITS; i < NB; i++) begin
            if (r_bcd[4*i +: 4] != 4'd0) begin
                w_ovf = 1'b1;
            end
        end
    end

    assign w_done   = r_busy && (r_cnt == CW'(VALUE_WIDTH));
    // A load on the commit edge starts the next conversion back-to-back.
    assign w_accept = load && (!r_busy || w_done);

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_bin  <= '0;
            r_bcd  <= '0;
            r_disp <= '0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_done) begin
                r_disp <= r_bcd[DIGITS*4-1:0];
                r_ovf  <= w_ovf;
            end
            if (w_accept) begin
                r_busy <= 1'b1;
                r_cnt  <= '0;
                r_bin  <= value;
                r_bcd  <= '0;
            end else if (w_done) begin
                r_busy <= 1'b0;
            end else if (r_busy) begin
                r_cnt  <= r_cnt + 1'b1;
                r_bcd  <= w_sh[SW-1 -: NB*4];
                r_bin  <= w_sh[VALUE_WIDTH-1:0];
            end
        end
    end

    assign w_bcd  = r_disp[4*int'(r_idx) +: 4];
    assign w_idx4 = 4'(r_idx);
    assign w_dp4  = {1'b0, dpPosition};

    always_comb begin
        case (w_bcd)
            4'd0:    w_code = 7'b1111110;
            4'd1:    w_code = 7'b0110000;
            4'd2:    w_code = 7'b1101101;
            4'd3:    w_code = 7'b1111001;
            4'd4:    w_code = 7'b0110011;
            4'd5:    w_code = 7'b1011011;
            4'd6:    w_code = 7'b1011111;
            4'd7:    w_code = 7'b1110000;
            4'd8:    w_code = 7'b1111111;
            4'd9:    w_code = 7'b1111011;
            default: w_code = 7'b0000000;
        endcase
    end

    // w_lead[i]: digit i and every digit above it are zero.
    always_comb begin
        w_lead = '0;
        w_z    = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_z       = w_z && (r_disp[4*i +: 4] == 4'd0);
            w_lead[i] = w_z;
        end
    end

    assign w_blank = blankZeros && w_lead[r_idx] && (r_idx != '0)
                   && !(dpEnable && (w_idx4 <= w_dp4));
    assign w_dp    = dpEnable && (w_dp4 == w_idx4);

    always_comb begin
        if (isError) begin
            w_seg = r_phase ? 8'b1001_1110 : 8'b0000_0000;
        end else if (r_ovf) begin
            w_seg = 8'b0000_0010;
        end else if (w_blank) begin
            w_seg = 8'b0000_0000;
        end else begin
            w_seg = {w_code, w_dp};
        end
    end

    assign w_onehot = DIGITS'(1) << r_idx;
    assign w_term   = (r_pre == PW'(SCAN_DIV - 1));
    assign w_wrap   = w_term && (r_idx == IW'(DIGITS - 1));

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_pre   <= '0;
            r_idx   <= '0;
            r_run   <= 1'b0;
            r_bcnt  <= '0;
            r_phase <= 1'b1;
            r_en    <= '0;
            r_seg   <= SEG_OFF;
        end else begin
            if (w_term) begin
                // One dark cycle between digits to avoid ghosting.
                r_pre <= '0;
                r_idx <= w_wrap ? '0 : r_idx + 1'b1;
                r_run <= 1'b1;
                r_en  <= '0;
                r_seg <= SEG_OFF;
            end else begin
                r_pre <= r_pre + 1'b1;
                if (r_run) begin
                    r_en  <= w_onehot;
                    r_seg <= w_seg ^ SEG_OFF;
                end
            end
            if (!isError) begin
                r_bcnt  <= '0;
                r_phase <= 1'b1;
            end else if (w_wrap) begin
                if (r_bcnt == BW'(BLINK_DIV - 1)) begin
                    r_bcnt  <= '0;
                    r_phase <= ~r_phase;
                end else begin
                    r_bcnt <= r_bcnt + 1'b1;
                end
            end
        end
    end

    assign busy        = r_busy;
    assign digitEnable = r_en;
    assign {A, B, C, D, E, F, G, DP} = r_seg;

endmodule
